wavegen_cmd_sequencer: RTL and testbench

//  Byte-command controller that configures the CORDIC waveform generator (sin/square/sawtooth/triangle).

---
 rtl/wavegen_pkg.sv | 33 +++
 rtl/wavegen_cmd_if.sv | 19 +
 rtl/sweep_stepper.sv | 55 +++++
 rtl/wavegen_cmd_sequencer.sv | 175 +++++++++++++++++
 tb/tb_wavegen_cmd_sequencer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/wavegen_pkg.sv
// Shared types for the wavegen command sequencer.
// Opcodes, waveform codes and FSM state encoding.
package wavegen_pkg;

  localparam logic [7:0] OP_NOP       = 8'h00;
  localparam logic [7:0] OP_SET_PHASE = 8'h01;
  localparam logic [7:0] OP_SET_AMP   = 8'h02;
  localparam logic [7:0] OP_SET_WAVE  = 8'h03;
  localparam logic [7:0] OP_ENABLE    = 8'h04;
  localparam logic [7:0] OP_SWEEP     = 8'h05;

  typedef enum logic [1:0] {
    SINUS        = 2'b00,
    SQUARE_PULSE = 2'b01,
    SAWTOOTH     = 2'b10,
    TRIANGLE     = 2'b11
  } wave_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPERAND,
    S_EXEC,
    S_SWEEP_WAIT,
    S_SWEEP_STEP
  } state_e;

  function automatic logic has_operand(
    input logic [7:0] b
  );
    return (b >= OP_SET_PHASE) && (b <= OP_SWEEP);
  endfunction

endpackage

// File: rtl/wavegen_cmd_if.sv
// Host command byte stream, valid/ready handshake.
// Master is the host bridge, slave is the sequencer.
interface wavegen_cmd_if;
  logic [7:0] cmd_data_i;
  logic       cmd_valid_i;
  logic       cmd_ready_o;

  modport master (
    output cmd_data_i,
    output cmd_valid_i,
    input  cmd_ready_o
  );

  modport slave (
    input  cmd_data_i,
    input  cmd_valid_i,
    output cmd_ready_o
  );
endinterface

// File: rtl/sweep_stepper.sv
// Sample-strobe divider and clamped amplitude step
// used by the sweep states of the sequencer.
module sweep_stepper #(
  parameter int SWEEP_DIV = 16,
  parameter int AMP_STEP  = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       strobe_i,
  input  logic [7:0] amp_i,
  input  logic [7:0] target_i,
  output logic       hit_o,
  output logic [7:0] next_amp_o
);

  localparam int CW =
    (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SWEEP_DIV - 1);
  localparam logic [7:0] STEP = 8'(AMP_STEP);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    gap;
  logic          up;

  assign hit_o = strobe_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || hit_o) begin
      cnt_d = '0;
    end else if (strobe_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // gap > STEP guarantees the step cannot overshoot or wrap
  always_comb begin
    up         = target_i > amp_i;
    gap        = up ? (target_i - amp_i) : (amp_i - target_i);
    next_amp_o = target_i;
    if (gap > STEP) begin
      next_amp_o = up ? (amp_i + STEP) : (amp_i - STEP);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wavegen_cmd_sequencer.sv
// Byte-command controller for the CORDIC waveform generator:
// opcode/operand decode plus strobe-paced amplitude sweeps.
module wavegen_cmd_sequencer
  import wavegen_pkg::*;
#(
  parameter int SWEEP_DIV = 16,
  parameter int AMP_STEP  = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  wavegen_cmd_if.slave cmd,
  input  logic         sample_strobe_i,
  output logic [7:0]   value_o,
  output logic         set_phase_o,
  output logic         set_amplitude_o,
  output logic [1:0]   waveform_o,
  output logic         enable_o,
  output logic         busy_o,
  output logic         err_o
);

  state_e     state_q, state_d;
  logic [7:0] op_q, op_d;
  logic [7:0] amp_q, amp_d;
  logic [7:0] tgt_q, tgt_d;
  logic [7:0] val_q, val_d;
  logic       sp_q, sp_d;
  logic       sa_q, sa_d;
  wave_e      wave_q, wave_d;
  logic       en_q, en_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;
  logic       rdy_q, rdy_d;

  logic       hs;
  logic       hit;
  logic [7:0] next_amp;
  logic [7:0] din;

  assign din = cmd.cmd_data_i;
  assign hs  = cmd.cmd_valid_i && rdy_q;

  sweep_stepper #(
    .SWEEP_DIV (SWEEP_DIV),
    .AMP_STEP  (AMP_STEP)
  ) u_step (
    .clk_i      (clk_i),
    .rst_ni     (rst_i),
    .clr_i      (state_q != S_SWEEP_WAIT),
    .strobe_i   (sample_strobe_i &&
                 (state_q == S_SWEEP_WAIT)),
    .amp_i      (amp_q),
    .target_i   (tgt_q),
    .hit_o      (hit),
    .next_amp_o (next_amp)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    amp_d   = amp_q;
    tgt_d   = tgt_q;
    val_d   = val_q;
    sp_d    = 1'b0;
    sa_d    = 1'b0;
    wave_d  = wave_q;
    en_d    = en_q;
    busy_d  = busy_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (hs) begin
          unique case (1'b1)
            din == OP_NOP: err_d = 1'b0;
            has_operand(din): begin
              op_d    = din;
              state_d = S_OPERAND;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_OPERAND: begin
        if (hs) begin
          state_d = S_EXEC;
          unique case (1'b1)
            op_q == OP_SET_PHASE: begin
              val_d = din;
              sp_d  = 1'b1;
            end
            op_q == OP_SET_AMP: begin
              val_d = din;
              amp_d = din;
              sa_d  = 1'b1;
            end
            op_q == OP_SET_WAVE:
              wave_d = wave_e'(din[1:0]);
            op_q == OP_ENABLE:
              en_d = din[0];
            op_q == OP_SWEEP: begin
              tgt_d  = din;
              busy_d = (din != amp_q);
            end
            default: ;
          endcase
        end
      end
      // busy_q is only set here by a sweep with real work
      S_EXEC: begin
        state_d = busy_q ? S_SWEEP_WAIT : S_IDLE;
      end
      S_SWEEP_WAIT: begin
        if (hit) begin
          amp_d   = next_amp;
          val_d   = next_amp;
          sa_d    = 1'b1;
          state_d = S_SWEEP_STEP;
        end
      end
      S_SWEEP_STEP: begin
        if (amp_q == tgt_q) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_SWEEP_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rdy_d = (state_d == S_IDLE) ||
            (state_d == S_OPERAND);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      amp_q   <= '0;
      tgt_q   <= '0;
      val_q   <= '0;
      sp_q    <= 1'b0;
      sa_q    <= 1'b0;
      wave_q  <= SINUS;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      amp_q   <= amp_d;
      tgt_q   <= tgt_d;
      val_q   <= val_d;
      sp_q    <= sp_d;
      sa_q    <= sa_d;
      wave_q  <= wave_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign cmd.cmd_ready_o  = rdy_q;
  assign value_o          = val_q;
  assign set_phase_o      = sp_q;
  assign set_amplitude_o  = sa_q;
  assign waveform_o       = wave_q;
  assign enable_o         = en_q;
  assign busy_o           = busy_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_wavegen_cmd_sequencer.sv
// Scoreboard bench for wavegen_cmd_sequencer: two instances
// (step 1 and step 4), strobe events checked by monitors.
module tb_wavegen_cmd_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [7:0] d_a, d_b;
  logic v_a, v_b, ss_a, ss_b;

  wavegen_cmd_if if_a ();
  wavegen_cmd_if if_b ();

  assign if_a.cmd_data_i  = d_a;
  assign if_a.cmd_valid_i = v_a;
  assign if_b.cmd_data_i  = d_b;
  assign if_b.cmd_valid_i = v_b;

  logic [7:0] val_a, val_b;
  logic sp_a, sp_b, sa_a, sa_b;
  logic [1:0] wv_a, wv_b;
  logic en_a, en_b, bz_a, bz_b, er_a, er_b;

  wavegen_cmd_sequencer #(
    .SWEEP_DIV (2),
    .AMP_STEP  (1)
  ) dut_a (
    .clk_i           (clk),
    .rst_i           (rst_n),
    .cmd             (if_a),
    .sample_strobe_i (ss_a),
    .value_o         (val_a),
    .set_phase_o     (sp_a),
    .set_amplitude_o (sa_a),
    .waveform_o      (wv_a),
    .enable_o        (en_a),
    .busy_o          (bz_a),
    .err_o           (er_a)
  );

  wavegen_cmd_sequencer #(
    .SWEEP_DIV (2),
    .AMP_STEP  (4)
  ) dut_b (
    .clk_i           (clk),
    .rst_i           (rst_n),
    .cmd             (if_b),
    .sample_strobe_i (ss_b),
    .value_o         (val_b),
    .set_phase_o     (sp_b),
    .set_amplitude_o (sa_b),
    .waveform_o      (wv_b),
    .enable_o        (en_b),
    .busy_o          (bz_b),
    .err_o           (er_b)
  );

  int total = 0;
  int bad   = 0;

  // {set_phase, set_amplitude, value}
  logic [9:0] q_a[$];
  logic [9:0] q_b[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sp_a || sa_a) begin
      if (q_a.size() == 0)
        check("a_unexpected_strobe", {sp_a, sa_a, val_a}, 0);
      else
        check("a_strobe", {sp_a, sa_a, val_a}, q_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (sp_b || sa_b) begin
      if (q_b.size() == 0)
        check("b_unexpected_strobe", {sp_b, sa_b, val_b}, 0);
      else
        check("b_strobe", {sp_b, sa_b, val_b}, q_b.pop_front());
    end
  end

  function automatic logic rdy(input bit b);
    return b ? if_b.cmd_ready_o : if_a.cmd_ready_o;
  endfunction

  task automatic send(input bit b, input logic [7:0] x);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy(b) && n < 100);
    if (n >= 100) check("ready_timeout", 0, 1);
    if (b) begin d_b = x; v_b = 1'b1; end
    else   begin d_a = x; v_a = 1'b1; end
    @(posedge clk);
    #1;
    v_a = 1'b0;
    v_b = 1'b0;
  endtask

  // returns at the negedge inside the EXEC cycle
  task automatic cmd(input bit b,
                     input logic [7:0] op,
                     input logic [7:0] arg);
    send(b, op);
    send(b, arg);
    @(negedge clk);
    check(b ? "b_exec_ready_low" : "a_exec_ready_low",
          {31'd0, rdy(b)}, 0);
  endtask

  task automatic strobes(input bit b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (b) ss_b = 1'b1; else ss_a = 1'b1;
      @(negedge clk);
      ss_a = 1'b0;
      ss_b = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    d_a = '0; d_b = '0;
    v_a = 1'b0; v_b = 1'b0;
    ss_a = 1'b0; ss_b = 1'b0;

    repeat (2) @(negedge clk);
    check("a_reset_outputs",
          {val_a, sp_a, sa_a, wv_a, en_a, bz_a, er_a,
           if_a.cmd_ready_o}, 0);
    check("b_reset_outputs",
          {val_b, sp_b, sa_b, wv_b, en_b, bz_b, er_b,
           if_b.cmd_ready_o}, 0);
    rst_n = 1'b1;

    q_a.push_back({2'b10, 8'h40});
    cmd(0, 8'h01, 8'h40);

    cmd(0, 8'h03, 8'h02);
    cmd(0, 8'h04, 8'h01);
    @(negedge clk);
    check("a_wave_enable", {wv_a, en_a}, {2'b10, 1'b1});

    send(0, 8'h7F);
    @(negedge clk);
    check("a_err_set", {31'd0, er_a}, 1);
    check("a_err_no_change", {wv_a, en_a, val_a},
          {2'b10, 1'b1, 8'h40});
    q_a.push_back({2'b10, 8'h11});
    cmd(0, 8'h01, 8'h11);
    check("a_err_sticky", {31'd0, er_a}, 1);
    send(0, 8'h00);
    @(negedge clk);
    check("a_nop_clears_err", {31'd0, er_a}, 0);

    q_a.push_back({2'b01, 8'h00});
    cmd(0, 8'h02, 8'h00);
    for (int i = 1; i <= 4; i++)
      q_a.push_back({2'b01, 8'(i)});
    cmd(0, 8'h05, 8'h04);
    check("a_busy_in_exec", {31'd0, bz_a}, 1);
    strobes(0, 7);
    check("a_busy_mid_sweep", {31'd0, bz_a}, 1);
    strobes(0, 1);
    repeat (2) @(negedge clk);
    check("a_sweep_done", {bz_a, if_a.cmd_ready_o},
          {1'b0, 1'b1});
    strobes(0, 4);
    check("a_idle_strobes_ignored", {31'd0, bz_a}, 0);

    q_b.push_back({2'b01, 8'hFA});
    cmd(1, 8'h02, 8'hFA);
    q_b.push_back({2'b01, 8'hFE});
    q_b.push_back({2'b01, 8'hFF});
    cmd(1, 8'h05, 8'hFF);
    strobes(1, 4);
    repeat (2) @(negedge clk);
    check("b_clamp_up_done", {bz_b, val_b},
          {1'b0, 8'hFF});
    cmd(1, 8'h05, 8'hFF);
    check("b_equal_target_not_busy", {31'd0, bz_b}, 0);
    strobes(1, 4);
    check("b_equal_target_idle", {bz_b, if_b.cmd_ready_o},
          {1'b0, 1'b1});
    q_b.push_back({2'b01, 8'hFB});
    q_b.push_back({2'b01, 8'hF9});
    cmd(1, 8'h05, 8'hF9);
    strobes(1, 4);
    repeat (2) @(negedge clk);
    check("b_clamp_down_done", {bz_b, val_b},
          {1'b0, 8'hF9});

    q_a.push_back({2'b01, 8'h05});
    q_a.push_back({2'b01, 8'h06});
    cmd(0, 8'h05, 8'h0A);
    strobes(0, 4);
    check("a_busy_before_reset", {31'd0, bz_a}, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("a_async_reset_outputs",
          {val_a, sp_a, sa_a, wv_a, en_a, bz_a, er_a,
           if_a.cmd_ready_o}, 0);
    check("b_async_reset_outputs",
          {val_b, wv_b, en_b, bz_b}, 0);
    strobes(0, 2);
    @(negedge clk);
    rst_n = 1'b1;
    strobes(0, 6);
    check("a_no_sweep_after_reset", {val_a, bz_a}, 0);
    q_a.push_back({2'b10, 8'h55});
    cmd(0, 8'h01, 8'h55);

    repeat (4) @(negedge clk);
    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
